// File: rtl/exponent_job_arbiter_if.sv
// Bundle of every signal between the exponent job arbiter and the outside world:
// the requester job/response channels, the shared power core and status outputs.
// The master view belongs to the arbiter; the slave view belongs to the requesters
// and the core together.
interface exponent_job_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int X_W   = 4,
  parameter int A_W   = 4,
  parameter int P_W   = 30
);
  logic [N_REQ-1:0]     i_req_valid;
  logic [N_REQ*X_W-1:0] i_req_x;
  logic [N_REQ*A_W-1:0] i_req_a;
  logic [N_REQ-1:0]     o_req_ready;
  logic [N_REQ-1:0]     o_rsp_valid;
  logic [N_REQ-1:0]     i_rsp_ready;
  logic [P_W-1:0]       o_rsp_p;
  logic                 o_rsp_err;
  logic                 o_core_load;
  logic                 o_core_start;
  logic [X_W-1:0]       o_core_x;
  logic [A_W-1:0]       o_core_a;
  logic                 i_core_done;
  logic [P_W-1:0]       i_core_p;
  logic                 o_busy;
  logic [2:0]           o_grant_id;

  modport master (
    input  i_req_valid, i_req_x, i_req_a, i_rsp_ready, i_core_done, i_core_p,
    output o_req_ready, o_rsp_valid, o_rsp_p, o_rsp_err, o_core_load, o_core_start,
           o_core_x, o_core_a, o_busy, o_grant_id
  );

  modport slave (
    output i_req_valid, i_req_x, i_req_a, i_rsp_ready, i_core_done, i_core_p,
    input  o_req_ready, o_rsp_valid, o_rsp_p, o_rsp_err, o_core_load, o_core_start,
           o_core_x, o_core_a, o_busy, o_grant_id
  );
endinterface

// File: rtl/exponent_job_arbiter.sv
// Round-robin scheduler sharing one P = X^A core between N_REQ requesters.
// One job at a time: grant, load, start, a guard cycle that masks a done level
// left over from the previous job, wait (with watchdog), then hold the response
// until its owner accepts it.
module exponent_job_arbiter #(
  parameter int N_REQ       = 4,
  parameter int X_W         = 4,
  parameter int A_W         = 4,
  parameter int P_W         = 30,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  exponent_job_arbiter_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_GUARD,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [2:0]       last_grant;
  logic [2:0]       grant_id;
  logic [X_W-1:0]   job_x;
  logic [A_W-1:0]   job_a;
  logic [P_W-1:0]   rsp_p;
  logic             rsp_err;
  logic [CNT_W-1:0] tmo_cnt;

  logic [7:0]       valid_ext;
  logic [7:0]       rsp_ready_ext;
  logic [3:0]       cand;
  logic             grant_found;
  logic [2:0]       grant_idx;
  logic [X_W-1:0]   sel_x;
  logic [A_W-1:0]   sel_a;
  logic             handshake;
  logic             timed_out;

  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] rsp_valid;
  logic             core_load;
  logic             core_start;
  logic             core_drive;
  logic [X_W-1:0]   core_x;
  logic [A_W-1:0]   core_a;
  logic             busy;

  assign valid_ext     = 8'(bus.i_req_valid);
  assign rsp_ready_ext = 8'(bus.i_rsp_ready);
  assign handshake     = rsp_ready_ext[grant_id];
  assign timed_out     = (tmo_cnt == TMO_LAST);

  // Pick the first pending request after the last served one, wrapping around.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_grant} + 4'(i);
      if (cand >= 4'(N_REQ)) cand = cand - 4'(N_REQ);
      if (!grant_found && valid_ext[cand[2:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[2:0];
      end
    end
  end

  // Route the winning requester's operands towards the job registers.
  always_comb begin
    sel_x = '0;
    sel_a = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (grant_idx == 3'(k)) begin
        sel_x = bus.i_req_x[k*X_W +: X_W];
        sel_a = bus.i_req_a[k*A_W +: A_W];
      end
    end
  end

  // State register; reset aborts any job in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state sequencing of one job through the core.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (grant_found) state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_START;
      ST_START: state_nxt = ST_GUARD;
      ST_GUARD: state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.i_core_done || timed_out) state_nxt = ST_RESP;
      ST_RESP:  if (handshake) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Job, result, watchdog and round-robin bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_grant <= 3'(N_REQ - 1);
      grant_id   <= '0;
      job_x      <= '0;
      job_a      <= '0;
      rsp_p      <= '0;
      rsp_err    <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            grant_id <= grant_idx;
            job_x    <= sel_x;
            job_a    <= sel_a;
          end
        end
        ST_GUARD: tmo_cnt <= '0;
        ST_WAIT: begin
          if (bus.i_core_done) begin
            rsp_p   <= bus.i_core_p;
            rsp_err <= 1'b0;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
            if (timed_out) begin
              rsp_p   <= '0;
              rsp_err <= 1'b1;
            end
          end
        end
        ST_RESP: if (handshake) last_grant <= grant_id;
        default: ;
      endcase
    end
  end

  // Decode handshake pulses and core controls from the current state.
  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    for (int k = 0; k < N_REQ; k++) begin
      req_ready[k] = (state == ST_IDLE) && grant_found && !i_rst && (grant_idx == 3'(k));
      rsp_valid[k] = (state == ST_RESP) && (grant_id == 3'(k));
    end
    core_load  = (state == ST_LOAD);
    core_start = (state == ST_START);
    core_drive = (state == ST_LOAD) || (state == ST_START) ||
                 (state == ST_GUARD) || (state == ST_WAIT);
    core_x     = core_drive ? job_x : '0;
    core_a     = core_drive ? job_a : '0;
    busy       = (state != ST_IDLE);
  end

  assign bus.o_req_ready  = req_ready;
  assign bus.o_rsp_valid  = rsp_valid;
  assign bus.o_rsp_p      = rsp_p;
  assign bus.o_rsp_err    = rsp_err;
  assign bus.o_core_load  = core_load;
  assign bus.o_core_start = core_start;
  assign bus.o_core_x     = core_x;
  assign bus.o_core_a     = core_a;
  assign bus.o_busy       = busy;
  assign bus.o_grant_id   = grant_id;

endmodule

// File: tb/tb_exponent_job_arbiter.sv
// Bench for exponent_job_arbiter: a transaction-level model predicts grants,
// core pulse timing and responses every cycle; directed scenarios pin literal results.
module tb_exponent_job_arbiter;

  localparam int N   = 4;
  localparam int XW  = 4;
  localparam int AW  = 4;
  localparam int PW  = 30;
  localparam int TMO = 16;

  logic clk;
  logic rst;

  int checks = 0;
  int errors = 0;

  // Core behaviour knobs, written only by the stimulus thread.
  bit never_done = 1'b0;
  int core_lat   = 3;

  exponent_job_arbiter_if #(.N_REQ(N), .X_W(XW), .A_W(AW), .P_W(PW)) bus ();

  exponent_job_arbiter #(
    .N_REQ(N), .X_W(XW), .A_W(AW), .P_W(PW), .TIMEOUT_CYC(TMO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [PW-1:0] pow_trunc(int x, int a);
    longint unsigned r = 1;
    for (int i = 0; i < a; i++) r = r * longint'(x);
    return r[PW-1:0];
  endfunction

  function automatic int pick(int last, logic [N-1:0] v);
    for (int i = 1; i <= N; i++) begin
      int c = (last + i) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic check_output(string name, longint unsigned actual, longint unsigned expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: actual=%0d required=%0d", name, $time, actual, expected);
    end
  endtask

  // Power core stand-in: result after core_lat cycles, and done stays high from the
  // previous job until the guard cycle so a stale completion is always present.
  int             core_cnt = 0;
  bit             core_drop = 1'b0;
  int             core_x_l = 0;
  int             core_a_l = 0;
  always @(negedge clk) begin
    if (rst) begin
      bus.i_core_done = 1'b0;
      bus.i_core_p    = '0;
      core_cnt        = 0;
      core_drop       = 1'b0;
    end else begin
      if (bus.o_core_load) begin
        core_x_l = int'(bus.o_core_x);
        core_a_l = int'(bus.o_core_a);
      end
      if (bus.o_core_start) begin
        core_cnt  = core_lat;
        core_drop = 1'b1;
      end else begin
        if (core_drop) begin
          bus.i_core_done = 1'b0;
          core_drop       = 1'b0;
        end
        if (core_cnt > 0) begin
          core_cnt--;
          if (core_cnt == 0 && !never_done) begin
            bus.i_core_done = 1'b1;
            bus.i_core_p    = pow_trunc(core_x_l, core_a_l);
          end
        end
      end
    end
  end

  // Transaction model and the per-cycle compare process.
  int  cyc = 0;
  bit  model_busy = 1'b0;
  int  model_last = N - 1;
  int  model_gid = 0;
  int  job_g, job_x, job_a, gc, resp_cyc;
  logic [PW-1:0] exp_p;
  bit  exp_err;
  int  hs_count = 0;
  int  load_count = 0;
  int  hs_id[$];
  longint unsigned hs_p[$];
  bit  hs_err[$];

  always @(negedge clk) begin
    bit busy_pre;
    int g;
    int c_s;
    logic [N-1:0] exp_ready;
    logic [N-1:0] exp_valid;
    cyc++;
    if (rst) begin
      check_output("reset_outputs",
        longint'({bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_p, bus.o_rsp_err, bus.o_core_load,
                  bus.o_core_start, bus.o_core_x, bus.o_core_a, bus.o_busy, bus.o_grant_id}), 0);
      model_busy = 1'b0;
      model_last = N - 1;
      model_gid  = 0;
    end else begin
      busy_pre  = model_busy;
      g         = -1;
      exp_ready = '0;
      if (!busy_pre) begin
        g = pick(model_last, bus.i_req_valid);
        if (g >= 0) exp_ready[g] = 1'b1;
      end
      check_output("req_ready", bus.o_req_ready, exp_ready);
      check_output("busy", bus.o_busy, busy_pre);
      check_output("grant_id", bus.o_grant_id, model_gid);
      if (busy_pre) begin
        check_output("core_load", bus.o_core_load, cyc == gc + 1);
        check_output("core_start", bus.o_core_start, cyc == gc + 2);
        if (bus.o_core_load) load_count++;
        if (cyc >= gc + 1 && cyc < resp_cyc) begin
          check_output("core_x", bus.o_core_x, job_x);
          check_output("core_a", bus.o_core_a, job_a);
        end
        exp_valid = '0;
        if (cyc >= resp_cyc) exp_valid[job_g] = 1'b1;
        check_output("rsp_valid", bus.o_rsp_valid, exp_valid);
        if (cyc >= resp_cyc) begin
          check_output("rsp_p", bus.o_rsp_p, exp_p);
          check_output("rsp_err", bus.o_rsp_err, exp_err);
          if (bus.i_rsp_ready[job_g]) begin
            hs_id.push_back(job_g);
            hs_p.push_back(bus.o_rsp_p);
            hs_err.push_back(bus.o_rsp_err);
            hs_count++;
            model_last = job_g;
            model_busy = 1'b0;
          end
        end
      end else begin
        check_output("idle_outputs",
          longint'({bus.o_core_load, bus.o_core_start, bus.o_rsp_valid}), 0);
      end
      if (g >= 0) begin
        model_busy = 1'b1;
        job_g      = g;
        model_gid  = g;
        job_x      = int'(bus.i_req_x[g*XW +: XW]);
        job_a      = int'(bus.i_req_a[g*AW +: AW]);
        gc         = cyc;
        c_s        = cyc + 2;
        if (never_done || core_lat > TMO + 1) begin
          resp_cyc = c_s + TMO + 2;
          exp_err  = 1'b1;
          exp_p    = '0;
        end else begin
          resp_cyc = c_s + core_lat + 1;
          exp_err  = 1'b0;
          exp_p    = pow_trunc(job_x, job_a);
        end
      end
    end
  end

  // One clock; requesters drop valid after the cycle in which they saw ready.
  task automatic tick();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = bus.o_req_ready & bus.i_req_valid;
    @(posedge clk);
    #1;
    bus.i_req_valid = bus.i_req_valid & ~acc;
  endtask

  task automatic apply_stimulus(int k, int x, int a);
    bus.i_req_x[k*XW +: XW] = XW'(x);
    bus.i_req_a[k*AW +: AW] = AW'(a);
    bus.i_req_valid[k]      = 1'b1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_hs(int target, int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      tick();
      n++;
    end
    if (hs_count < target) check_output("hs_wait_expired", hs_count, target);
  endtask

  task automatic check_hs(string name, int idx, int id, longint unsigned p, bit err);
    int              a_id = -1;
    longint unsigned a_p = 0;
    bit              a_err = 1'b0;
    if (idx < hs_id.size()) begin
      a_id  = hs_id[idx];
      a_p   = hs_p[idx];
      a_err = hs_err[idx];
    end
    check_output({name, "_id"}, longint'(a_id), longint'(id));
    check_output({name, "_p"}, a_p, p);
    check_output({name, "_err"}, a_err, err);
  endtask

  initial begin
    int base;
    int lc;
    int n;
    rst             = 1'b1;
    bus.i_req_valid = '0;
    bus.i_req_x     = '0;
    bus.i_req_a     = '0;
    bus.i_rsp_ready = '1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_output("post_reset_busy", bus.o_busy, 0);

    $display("[TB] single job 2^3");
    apply_stimulus(0, 2, 3);
    wait_hs(1, 40);
    check_hs("single", 0, 0, 8, 0);
    check_output("single_loads", load_count, 1);

    $display("[TB] max magnitude 9^9");
    apply_stimulus(1, 9, 9);
    wait_hs(2, 40);
    check_hs("max", 1, 1, 387420489, 0);
    check_output("max_grant_id", bus.o_grant_id, 1);

    $display("[TB] round-robin order");
    apply_reset();
    base = hs_count;
    apply_stimulus(0, 2, 2);
    apply_stimulus(2, 3, 2);
    apply_stimulus(3, 1, 5);
    wait_hs(base + 3, 120);
    check_hs("rr0", base + 0, 0, 4, 0);
    check_hs("rr1", base + 1, 2, 9, 0);
    check_hs("rr2", base + 2, 3, 1, 0);
    apply_stimulus(0, 2, 1);
    apply_stimulus(3, 3, 3);
    wait_hs(base + 5, 80);
    check_hs("rr_wrap0", base + 3, 0, 2, 0);
    check_hs("rr_wrap1", base + 4, 3, 27, 0);

    $display("[TB] backpressure");
    base = hs_count;
    bus.i_rsp_ready = 4'b1110;
    apply_stimulus(0, 5, 2);
    apply_stimulus(1, 4, 3);
    n = 0;
    while (!bus.o_rsp_valid[0] && n < 40) begin
      tick();
      n++;
    end
    check_output("bp_valid_seen", bus.o_rsp_valid[0], 1);
    lc = load_count;
    repeat (5) begin
      tick();
      check_output("bp_valid_hold", bus.o_rsp_valid, 4'b0001);
      check_output("bp_p_hold", bus.o_rsp_p, 25);
    end
    check_output("bp_no_new_load", load_count, lc);
    check_output("bp_no_handshake", hs_count, base);
    bus.i_rsp_ready = '1;
    wait_hs(base + 2, 60);
    check_hs("bp0", base + 0, 0, 25, 0);
    check_hs("bp1", base + 1, 1, 64, 0);

    $display("[TB] watchdog");
    base = hs_count;
    never_done = 1'b1;
    apply_stimulus(2, 3, 4);
    wait_hs(base + 1, 80);
    check_hs("tmo", base + 0, 2, 0, 1);
    never_done = 1'b0;
    core_lat   = TMO + 1;
    apply_stimulus(2, 3, 4);
    wait_hs(base + 2, 80);
    check_hs("tmo_done_wins", base + 1, 2, 81, 0);
    core_lat = TMO + 2;
    apply_stimulus(2, 2, 5);
    wait_hs(base + 3, 80);
    check_hs("tmo_late_done", base + 2, 2, 0, 1);
    core_lat = 3;
    apply_stimulus(2, 2, 5);
    wait_hs(base + 4, 80);
    check_hs("tmo_recover", base + 3, 2, 32, 0);

    $display("[TB] reset during wait");
    core_lat = 10;
    apply_stimulus(1, 2, 2);
    n = 0;
    while (!bus.o_core_start && n < 20) begin
      tick();
      n++;
    end
    check_output("abort_start_seen", bus.o_core_start, 1);
    repeat (3) tick();
    base = hs_count;
    rst = 1'b1;
    #1;
    check_output("abort_async_zero",
      longint'({bus.o_req_ready, bus.o_rsp_valid, bus.o_rsp_p, bus.o_rsp_err, bus.o_core_load,
                bus.o_core_start, bus.o_busy, bus.o_grant_id}), 0);
    repeat (2) tick();
    rst      = 1'b0;
    core_lat = 3;
    check_output("abort_no_response", hs_count, base);
    apply_stimulus(0, 3, 1);
    apply_stimulus(1, 2, 2);
    wait_hs(base + 2, 60);
    check_hs("after_abort0", base + 0, 0, 3, 0);
    check_hs("after_abort1", base + 1, 1, 4, 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL global_timeout: actual=running required=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] global time limit reached");
  end

endmodule

// File: doc/exponent_job_arbiter.md
Name: exponent_job_arbiter

Overview:
- Scheduler that shares one power-function core (P = X^A; load/start/done handshake; 4-bit X and A; 30-bit P) between N_REQ requesters.
- Accepts jobs with round-robin arbitration and sequences the core's load, start and done phases.
- Returns each result to its owner with a valid/ready handshake, plus a watchdog timeout.
- Sits between the AXI4-Lite register front-ends/clients and the single core instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- X_W, 4, base width.
- A_W, 4, exponent width.
- P_W, 30, result width.
- TIMEOUT_CYC, 255, maximum WAIT cycles before the job is aborted with an error.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_rst  in  1  asynchronous active-high reset.
- i_req_valid  in  N_REQ  per-requester job request.
- i_req_x  in  N_REQ*X_W  packed bases; requester k uses bits [k*X_W +: X_W].
- i_req_a  in  N_REQ*A_W  packed exponents, same packing as i_req_x.
- o_req_ready  out  N_REQ  one-hot, 1-cycle pulse; the job is accepted in that cycle.
- o_rsp_valid  out  N_REQ  one-hot; the result is valid for that requester.
- i_rsp_ready  in  N_REQ  per-requester result acceptance.
- o_rsp_p  out  P_W  result (shared bus; qualified by o_rsp_valid).
- o_rsp_err  out  1  1 = job timed out; qualified by o_rsp_valid.
- o_core_load  out  1  core load pulse.
- o_core_start  out  1  core start pulse.
- o_core_x  out  X_W  base driven to the core.
- o_core_a  out  A_W  exponent driven to the core.
- i_core_done  in  1  core completion flag (level).
- i_core_p  in  P_W  core result.
- o_busy  out  1  high in any state other than IDLE.
- o_grant_id  out  3  index of the current or last granted requester.

Behaviour:
- Reset (async, i_rst=1):
  - All outputs 0. State = IDLE. Timeout counter = 0.
  - Round-robin pointer: last_grant = N_REQ-1, so requester 0 has first priority.
- FSM states: IDLE, LOAD, START, GUARD, WAIT, RESP.
- IDLE:
  - If any i_req_valid is set, grant the first set bit searching from last_grant+1 upward, wrapping modulo N_REQ.
  - In the same cycle: pulse o_req_ready[g]=1, latch i_req_x/i_req_a slices of g into job registers, set o_grant_id=g, go to LOAD.
  - Requests not granted stay pending. The requester must hold valid and data until it sees ready.
- LOAD: o_core_load=1 for exactly 1 cycle. o_core_x/o_core_a driven from the job registers and held through WAIT. Go to START.
- START: o_core_start=1 for exactly 1 cycle. Go to GUARD.
- GUARD:
  - 1 cycle; i_core_done is ignored, because done may still be high from the previous job.
  - Clear the timeout counter. Go to WAIT.
- WAIT:
  - Each cycle: if i_core_done=1, capture i_core_p into o_rsp_p, set o_rsp_err=0, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYC, set o_rsp_p=0 and o_rsp_err=1, go to RESP.
  - Done wins if it is asserted in the same cycle the counter reaches TIMEOUT_CYC.
- RESP:
  - Hold o_rsp_valid[g]=1 with o_rsp_p and o_rsp_err stable until i_rsp_ready[g]=1.
  - In that handshake cycle: update last_grant=g. Next cycle o_rsp_valid=0 and state = IDLE.
  - i_rsp_ready bits of other requesters are ignored.
- Latency, done-to-valid: o_rsp_valid rises the cycle after i_core_done is sampled high in WAIT.
- Throughput: a new grant is possible no earlier than 1 cycle after the response handshake, so there is no overlap of jobs.
- Fairness: a requester that keeps i_req_valid high waits at most N_REQ-1 jobs.
- Widths: job registers are zero-extended internally. o_rsp_p is exactly i_core_p with no saturation; overflow is the core's responsibility.
- Reset mid-operation: abort immediately, drop any load/start pulse, discard the job. The requester gets no response.
- A requester with i_req_valid high during RESP of another requester is served only after the return to IDLE.

Test Plan:
- Single job: req0 X=2, A=3 -> o_req_ready[0] pulse; one load then one start pulse; o_rsp_valid[0] with o_rsp_p=8, o_rsp_err=0.
- Max-magnitude job: req1 X=9, A=9 -> o_rsp_p=387420489 (fits 30 bits), err=0, o_grant_id=1.
- Arbitration: req0 (2^2), req2 (3^2), req3 (1^5) all held high from reset -> grant order 0, 2, 3; results 4, 9, 1. Then re-raise req0 and req3 together after the last grant (3) -> req0 is granted first.
- Backpressure: hold i_rsp_ready[0]=0 for 5 cycles after valid -> o_rsp_valid[0] and o_rsp_p stay stable; no new load pulse until the handshake.
- Timeout: core model never asserts done, TIMEOUT_CYC=16 -> o_rsp_valid with err=1, p=0, exactly 16 WAIT cycles after GUARD. Then a new job completes normally.
- Stale done and reset: i_core_done held high from the previous job through START/GUARD is not taken as completion. Assert i_rst during WAIT -> all outputs 0 asynchronously; after release, req0 is granted first again.
